idct2d_ctrl: RTL and testbench

Sequencing controller for the 8-lane IDCT datapath. It accepts one 8x8 coefficient block (2048 bits) over a valid/ready handshake and drives the datapath for a row pass, then for a column pass, transposing between the two. It returns the finished pixel block over a valid/ready handshake. It sits between the dequantiser output and the colour-conversion input, and owns the datapath's `data_in`, `s_valid` and `shift_amount`.

---
 rtl/idct_pkg.sv | 22 ++
 rtl/idct_transpose.sv | 15 +
 rtl/idct2d_ctrl.sv | 161 ++++++++++++++++
 tb/tb_idct2d_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants, FSM state type and lane addressing for the 2-D IDCT sequencer.
package idct_pkg;

    localparam int BLK_W  = 2048;
    localparam int ROW_W  = 256;
    localparam int LANE_W = 32;
    localparam int N      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_ISSUE,
        S_ROW_WAIT,
        S_COL_ISSUE,
        S_COL_WAIT,
        S_OUT
    } idct_state_t;

    function automatic int lane_off(input int r, input int c);
        return r * ROW_W + c * LANE_W;
    endfunction

endpackage

// File: rtl/idct_transpose.sv
// Combinational 8x8 lane transpose of a 2048-bit block: lane (r,c) moves to (c,r).
module idct_transpose
    import idct_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign dout[lane_off(c, r) +: LANE_W] = din[lane_off(r, c) +: LANE_W];
        end
    end

endmodule

// File: rtl/idct2d_ctrl.sv
// Row/column pass sequencer for the 8-lane IDCT datapath with watchdog and sticky error.
// Optional output saturation to 0..255 after a +128 bias when IDCT_CTRL_CLAMP_EN is defined.
//
// state       | meaning
// S_IDLE      | waiting for an input block, s_ready high
// S_ROW_ISSUE | one-cycle launch of the row pass
// S_ROW_WAIT  | waiting for the row result, watchdog running
// S_COL_ISSUE | one-cycle launch of the column pass on the transposed block
// S_COL_WAIT  | waiting for the column result, watchdog running
// S_OUT       | presenting the pixel block until m_ready
module idct2d_ctrl
    import idct_pkg::*;
#(
    parameter int ROW_SHIFT = 11,
    parameter int COL_SHIFT = 18,
    parameter int TIMEOUT   = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLK_W-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLK_W-1:0]   m_data,
    output logic [BLK_W-1:0]   idct_data,
    output logic               idct_valid,
    output logic [4:0]         idct_shift,
    input  logic [BLK_W-1:0]   idct_result,
    input  logic               idct_done,
    output logic               err,
    output logic [15:0]        blk_cnt
);

    idct_state_t        state, state_nxt;
    logic [BLK_W-1:0]   work_q, out_q;
    logic [BLK_W-1:0]   row_t, col_t, col_post;
    logic [4:0]         shift_q;
    logic [15:0]        wdog_q;
    logic [15:0]        blk_cnt_q;
    logic               err_q;

    logic ld_in, ld_row, ld_out, wdog_ld, set_err, blk_inc, shift_row, shift_col;

    idct_transpose u_tr_row (.din(idct_result), .dout(row_t));
    idct_transpose u_tr_col (.din(idct_result), .dout(col_t));

    always_comb begin
        col_post = col_t;
`ifdef IDCT_CTRL_CLAMP_EN
        for (int i = 0; i < N * N; i++) begin
            logic [32:0] sum;
            sum = {col_t[i*LANE_W + LANE_W-1], col_t[i*LANE_W +: LANE_W]} + 33'd128;
            if (sum[32])
                col_post[i*LANE_W +: LANE_W] = '0;
            else if (sum > 33'd255)
                col_post[i*LANE_W +: LANE_W] = 32'd255;
            else
                col_post[i*LANE_W +: LANE_W] = sum[31:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ld_in      = 1'b0;
        ld_row     = 1'b0;
        ld_out     = 1'b0;
        wdog_ld    = 1'b0;
        set_err    = 1'b0;
        blk_inc    = 1'b0;
        shift_row  = 1'b0;
        shift_col  = 1'b0;
        s_ready    = (state == S_IDLE);
        m_valid    = (state == S_OUT);
        idct_valid = (state == S_ROW_ISSUE) || (state == S_COL_ISSUE);
        case (state)
            S_IDLE: if (s_valid) begin
                ld_in     = 1'b1;
                shift_row = 1'b1;
                state_nxt = S_ROW_ISSUE;
            end
            S_ROW_ISSUE: begin
                wdog_ld   = 1'b1;
                state_nxt = S_ROW_WAIT;
            end
            // idct_done is checked first so a result on the expiry cycle still wins
            S_ROW_WAIT: if (idct_done) begin
                ld_row    = 1'b1;
                shift_col = 1'b1;
                state_nxt = S_COL_ISSUE;
            end else if (wdog_q == '0) begin
                set_err   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_COL_ISSUE: begin
                wdog_ld   = 1'b1;
                state_nxt = S_COL_WAIT;
            end
            S_COL_WAIT: if (idct_done) begin
                ld_out    = 1'b1;
                state_nxt = S_OUT;
            end else if (wdog_q == '0) begin
                set_err   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_OUT: if (m_ready) begin
                blk_inc   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (idct_done && state != S_ROW_WAIT && state != S_COL_WAIT)
            set_err = 1'b1;
    end

    // watchdog loads TIMEOUT on issue, so expiry lands on the (TIMEOUT+1)th wait cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_q    <= '0;
            out_q     <= '0;
            shift_q   <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            if (ld_in)
                work_q <= s_data;
            else if (ld_row)
                work_q <= row_t;
            if (ld_out)
                out_q <= col_post;
            if (shift_row)
                shift_q <= 5'(ROW_SHIFT);
            else if (shift_col)
                shift_q <= 5'(COL_SHIFT);
            if (wdog_ld)
                wdog_q <= 16'(TIMEOUT);
            else if (wdog_q != '0)
                wdog_q <= wdog_q - 16'd1;
            if (set_err)
                err_q <= 1'b1;
            if (blk_inc)
                blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign m_data     = out_q;
    assign idct_data  = work_q;
    assign idct_shift = shift_q;
    assign err        = err_q;
    assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_idct2d_ctrl.sv
// Scoreboard bench for idct2d_ctrl with an identity datapath stub of latency 3.
module tb_idct2d_ctrl;
    import idct_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [BLK_W-1:0]   s_data = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [BLK_W-1:0]   m_data;
    logic [BLK_W-1:0]   idct_data;
    logic               idct_valid;
    logic [4:0]         idct_shift;
    logic [BLK_W-1:0]   idct_result;
    logic               idct_done;
    logic               err;
    logic [15:0]        blk_cnt;

    idct2d_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .idct_data(idct_data), .idct_valid(idct_valid), .idct_shift(idct_shift),
        .idct_result(idct_result), .idct_done(idct_done),
        .err(err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    // identity datapath stub, not reset by rst so in-flight results survive a reset
    logic [2:0]         pv = '0;
    logic [BLK_W-1:0]   pd0 = '0, pd1 = '0, pd2 = '0;
    bit                 stub_hang = 1'b0;
    always @(posedge clk) begin
        pv  <= {pv[1:0], idct_valid};
        pd0 <= idct_data;
        pd1 <= pd0;
        pd2 <= pd1;
    end
    assign idct_done   = pv[2] && !stub_hang;
    assign idct_result = pd2;

    int                 checks = 0, errors = 0;
    int                 cyc = 0;
    int                 acc_cyc = 0;
    int                 issue_n = 0;
    logic [BLK_W-1:0]   cur_in = '0;
    logic [BLK_W-1:0]   exp_q[$];
    logic               prev_mv = 1'b0, prev_mr = 1'b0;
    logic [BLK_W-1:0]   held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N * N; i++) begin
                if (act[i*LANE_W +: LANE_W] !== exp[i*LANE_W +: LANE_W]) begin
                    $display("FAIL %s lane r%0d c%0d got %0d want %0d (cycle %0d)", nm, i / N, i % N,
                             $signed(act[i*LANE_W +: LANE_W]), $signed(exp[i*LANE_W +: LANE_W]), cyc);
                    break;
                end
            end
        end
    endtask

    function automatic logic [BLK_W-1:0] tr(input logic [BLK_W-1:0] b);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                o[lane_off(c, r) +: LANE_W] = b[lane_off(r, c) +: LANE_W];
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] mk_seq(input int base);
        logic [BLK_W-1:0] o;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                o[lane_off(r, c) +: LANE_W] = 32'(base + 8 * r + c);
        return o;
    endfunction

    // lanes cycle -200 / 100 / 200
    function automatic logic [BLK_W-1:0] mk_clamp_in();
        logic [BLK_W-1:0] o;
        int vals[3] = '{-200, 100, 200};
        for (int i = 0; i < N * N; i++) o[i*LANE_W +: LANE_W] = 32'(vals[i % 3]);
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] mk_clamp_exp();
        logic [BLK_W-1:0] o;
`ifdef IDCT_CTRL_CLAMP_EN
        int vals[3] = '{0, 228, 255};
`else
        int vals[3] = '{-200, 100, 200};
`endif
        for (int i = 0; i < N * N; i++) o[i*LANE_W +: LANE_W] = 32'(vals[i % 3]);
        return o;
    endfunction

    // raw identity round trip; under clamp only small nonnegative lanes are used so +128 applies
    function automatic logic [BLK_W-1:0] seq_exp(input logic [BLK_W-1:0] b);
`ifdef IDCT_CTRL_CLAMP_EN
        logic [BLK_W-1:0] o;
        for (int i = 0; i < N * N; i++) o[i*LANE_W +: LANE_W] = b[i*LANE_W +: LANE_W] + 32'd128;
        return o;
`else
        return b;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (idct_valid) begin
                if (issue_n == 0) begin
                    chk("row_shift", idct_shift, 11);
                    chk_blk("row_data", idct_data, cur_in);
                end else begin
                    chk("col_shift", idct_shift, 18);
                    chk_blk("col_data", idct_data, tr(cur_in));
                end
                issue_n = issue_n + 1;
            end
            if (m_valid && !prev_mv) chk("m_valid_latency", cyc - acc_cyc, 9);
            if (m_valid && prev_mv && !prev_mr) begin
                chk_blk("m_data_stable", m_data, held);
                chk("s_ready_backpressure", s_ready, 0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output m_valid=1 want no output (cycle %0d)", cyc);
                end else begin
                    chk_blk("m_data", m_data, exp_q.pop_front());
                end
            end
            prev_mv = m_valid;
            prev_mr = m_ready;
            held    = m_data;
        end else begin
            prev_mv = 1'b0;
            prev_mr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [BLK_W-1:0] d, input bit push, input logic [BLK_W-1:0] e);
        int k;
        for (k = 0; k < 300; k++) begin
            if (s_ready) break;
            tick();
        end
        if (k == 300) chk("s_ready_wait_timeout", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        cur_in  = d;
        issue_n = 0;
        acc_cyc = cyc;
        if (push) exp_q.push_back(e);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [BLK_W-1:0] a;
        int acc_b;
        a = mk_seq(0);

        repeat (2) tick();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_idct_valid", idct_valid, 0);
        chk("rst_idct_shift", idct_shift, 0);
        chk_blk("rst_idct_data", idct_data, '0);
        chk_blk("rst_m_data", m_data, '0);
        chk("rst_err", err, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        rst = 1'b1;
        tick();

        m_ready = 1'b1;
        send_block(a, 1'b1, seq_exp(a));
        wait_empty();
        chk("blk_cnt_1", blk_cnt, 1);
        chk("idct_shift_hold", idct_shift, 18);

        send_block(mk_seq(1), 1'b1, seq_exp(mk_seq(1)));
        acc_b = acc_cyc;
        send_block(mk_seq(40), 1'b1, seq_exp(mk_seq(40)));
        chk("throughput_period", acc_cyc - acc_b, 10);
        wait_empty();
        chk("blk_cnt_3", blk_cnt, 3);

        send_block(mk_clamp_in(), 1'b1, mk_clamp_exp());
        wait_empty();
        chk("blk_cnt_4", blk_cnt, 4);

        m_ready = 1'b0;
        send_block(mk_seq(7), 1'b1, seq_exp(mk_seq(7)));
        for (int k = 0; k < 50 && !m_valid; k++) tick();
        chk("bp_m_valid", m_valid, 1);
        repeat (10) tick();
        chk("bp_m_valid_held", m_valid, 1);
        m_ready = 1'b1;
        wait_empty();
        chk("blk_cnt_5", blk_cnt, 5);
        chk("err_before_timeout", err, 0);

        stub_hang = 1'b1;
        send_block(mk_seq(3), 1'b0, '0);
        for (int k = 0; k < 200 && !err; k++) tick();
        chk("timeout_err", err, 1);
        chk("timeout_cycle", cyc - acc_cyc, 66);
        chk("timeout_s_ready", s_ready, 1);
        repeat (20) tick();
        stub_hang = 1'b0;
        chk("timeout_blk_cnt", blk_cnt, 5);

        send_block(mk_seq(5), 1'b0, '0);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_idct_valid", idct_valid, 0);
        chk("mid_rst_idct_shift", idct_shift, 0);
        chk_blk("mid_rst_idct_data", idct_data, '0);
        chk_blk("mid_rst_m_data", m_data, '0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_blk_cnt", blk_cnt, 0);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("stray_err", err, 1);

        send_block(mk_seq(9), 1'b1, seq_exp(mk_seq(9)));
        wait_empty();
        chk("post_rst_blk_cnt", blk_cnt, 1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
